// File: rtl/mem_uart.sv
// Memory-mapped 8N1 UART responder for the picorv32 native memory bus.
// TX/RX FIFOs, fixed-divider bit timing, W1C sticky error flags and a level interrupt.
module mem_uart #(
   parameter int unsigned CLK_DIV    = 217,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [1:0]  mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   input  logic        rxd,
   output logic        txd,
   output logic        irq
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BitLast  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HalfLast = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] CntOne   = CW'(1);
   localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
   localparam logic [AW:0]   PtrFull  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

   // Bus request captured on acceptance; side effects happen while ready_q is high.
   logic       ready_q, req_wr_q, req_b0_q;
   logic [1:0] req_addr_q;
   logic [7:0] req_data_q;

   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
   logic        rxovr_q, frameerr_q, txovr_q, irq_q;
   logic [1:0]  ctrl_q;

   tx_state_e   tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [2:0]  tx_bit_q;
   logic [7:0]  tx_sh_q;
   logic        txd_q;

   rx_state_e   rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]  rx_bit_q;
   logic [7:0]  rx_sh_q;
   logic        rx_s1_q, rx_s2_q;

   logic        tx_empty, tx_full, rx_empty, rx_full, tx_idle;
   logic        bus_wr_data, tx_pop, tx_push, tx_ovr_set;
   logic        rx_pop, rx_done, rx_push_req, rx_push, rx_ovr_set, fe_set;
   logic [2:0]  w1c;
   logic [7:0]  tx_head, rx_head;
   logic [31:0] status;
   logic        unused_bits;

   assign unused_bits = ^mem_wdata[31:8];

   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = ((tx_wr_q ^ tx_rd_q) == PtrFull);
   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = ((rx_wr_q ^ rx_rd_q) == PtrFull);
   assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
   assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];
   assign tx_idle  = tx_empty && (tx_state_q == TxIdle);

   assign bus_wr_data = ready_q && (req_addr_q == 2'd0) && req_b0_q;
   assign tx_pop      = (tx_state_q == TxIdle) && !tx_empty;
   assign tx_push     = bus_wr_data && (!tx_full || tx_pop);
   assign tx_ovr_set  = bus_wr_data && tx_full && !tx_pop;

   assign rx_pop      = ready_q && !req_wr_q && (req_addr_q == 2'd0) && !rx_empty;
   assign rx_done     = (rx_state_q == RxStop) && (rx_cnt_q == BitLast);
   assign rx_push_req = rx_done && rx_s2_q;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);
   assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop;
   assign fe_set      = rx_done && !rx_s2_q;

   assign w1c = (ready_q && (req_addr_q == 2'd1) && req_b0_q) ? req_data_q[5:3] : 3'b000;

   assign status = {26'h0, txovr_q, frameerr_q, rxovr_q, tx_idle, tx_full, !rx_empty};

   assign mem_ready = ready_q;
   assign txd       = txd_q;
   assign irq       = irq_q;

   always_comb begin
      mem_rdata = '0;
      if (ready_q && !req_wr_q) begin
         case (req_addr_q)
            2'd0:    mem_rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            2'd1:    mem_rdata = status;
            2'd2:    mem_rdata = {30'h0, ctrl_q};
            default: mem_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         req_wr_q   <= 1'b0;
         req_b0_q   <= 1'b0;
         req_addr_q <= 2'd0;
         req_data_q <= 8'h0;
      end else begin
         ready_q <= mem_valid && !ready_q;
         if (mem_valid && !ready_q) begin
            req_addr_q <= mem_addr;
            req_wr_q   <= |mem_wstrb;
            req_b0_q   <= mem_wstrb[0];
            req_data_q <= mem_wdata[7:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rxovr_q    <= 1'b0;
         frameerr_q <= 1'b0;
         txovr_q    <= 1'b0;
         ctrl_q     <= 2'b00;
         irq_q      <= 1'b0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + PtrOne;
         if (tx_pop)  tx_rd_q <= tx_rd_q + PtrOne;
         if (rx_push) rx_wr_q <= rx_wr_q + PtrOne;
         if (rx_pop)  rx_rd_q <= rx_rd_q + PtrOne;
         // Set takes priority over a same-cycle W1C clear.
         rxovr_q    <= rx_ovr_set | (rxovr_q & ~w1c[0]);
         frameerr_q <= fe_set | (frameerr_q & ~w1c[1]);
         txovr_q    <= tx_ovr_set | (txovr_q & ~w1c[2]);
         if (ready_q && (req_addr_q == 2'd2) && req_b0_q) ctrl_q <= req_data_q[1:0];
         irq_q <= (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_empty);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= req_data_q;
      if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_sh_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_sh_q    <= 8'h0;
         txd_q      <= 1'b1;
      end else begin
         unique case (tx_state_q)
            TxIdle: begin
               txd_q <= 1'b1;
               if (!tx_empty) begin
                  tx_sh_q    <= tx_head;
                  tx_cnt_q   <= '0;
                  txd_q      <= 1'b0;
                  tx_state_q <= TxStart;
               end
            end
            TxStart: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= 3'd0;
                  txd_q      <= tx_sh_q[0];
                  tx_state_q <= TxData;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntOne;
               end
            end
            TxData: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     txd_q      <= 1'b1;
                     tx_state_q <= TxStop;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     txd_q    <= tx_sh_q[1];
                     tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntOne;
               end
            end
            TxStop: begin
               if (tx_cnt_q == BitLast) begin
                  tx_cnt_q   <= '0;
                  tx_state_q <= TxIdle;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntOne;
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_sh_q    <= 8'h0;
      end else begin
         rx_s1_q <= rxd;
         rx_s2_q <= rx_s1_q;
         unique case (rx_state_q)
            RxIdle: begin
               if (!rx_s2_q) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RxStart;
               end
            end
            RxStart: begin
               // Mid start bit: a high level here means the edge was a glitch.
               if (rx_cnt_q == HalfLast) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= 3'd0;
                  rx_state_q <= rx_s2_q ? RxIdle : RxData;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntOne;
               end
            end
            RxData: begin
               if (rx_cnt_q == BitLast) begin
                  rx_cnt_q <= '0;
                  rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                  else                  rx_bit_q   <= rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntOne;
               end
            end
            RxStop: begin
               if (rx_cnt_q == BitLast) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= rx_s2_q ? RxIdle : RxWait;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntOne;
               end
            end
            RxWait: begin
               if (rx_s2_q) rx_state_q <= RxIdle;
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

endmodule
